// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    // A nibble at or above this value gets +3 before the next shift.
    localparam logic [3:0] NIBBLE_ADJ_THRESH = 4'd5;

    // Largest value representable with the given number of decimal digits.
    function automatic int unsigned bcd_max(input int unsigned digits);
        int unsigned result;
        result = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            result = result * 10;
        end
        return result - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and data bus between a requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);

    logic                  start;
    logic [BIN_WIDTH-1:0]  bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble nibble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pure 4-bit add with no carry out; digits never exceed 9 before adjust.
    always_comb begin
        dout = din;
        if (din >= NIBBLE_ADJ_THRESH) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Values above the digit range saturate to all nines and raise ovf.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic            clk,
    input  logic            reset,
    bin2bcd_seq_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CW    = $clog2(BIN_WIDTH + 1);
    localparam int unsigned MAX_VAL = bcd_max(DIGITS);

    bcd_state_t         state;
    bcd_state_t         state_next;
    logic [SR_W-1:0]    shift_reg;
    logic [SR_W-1:0]    shift_reg_shifted;
    logic [BCD_W-1:0]   adj_field;
    logic [CW-1:0]      bit_cnt;
    logic               ovf_pending;
    logic               ovf_next;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               busy_o;
    logic               done_o;
    logic               capture;
    logic               last_shift;

    // A new request is taken whenever the converter is not mid-shift,
    // which includes the DONE cycle so back-to-back runs lose no cycle.
    assign capture    = bus.start && (state != SHIFT);
    assign last_shift = (state == SHIFT) && (bit_cnt == CW'(1));
    assign ovf_next   = (32'(bus.bin) > MAX_VAL);

    // All digits are corrected in parallel from the current register contents.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (shift_reg[BIN_WIDTH + 4*g +: 4]),
                .dout (adj_field[4*g +: 4])
            );
        end
    endgenerate

    assign shift_reg_shifted = {adj_field, shift_reg[BIN_WIDTH-1:0]} << 1;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the SHIFT phase lasts exactly BIN_WIDTH cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (bit_cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded purely from the registered state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            SHIFT:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Shift register, bit counter and pending overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
        end else if (capture) begin
            shift_reg   <= {{BCD_W{1'b0}}, bus.bin};
            bit_cnt     <= CW'(BIN_WIDTH);
            ovf_pending <= ovf_next;
        end else if (state == SHIFT) begin
            shift_reg   <= shift_reg_shifted;
            bit_cnt     <= bit_cnt - CW'(1);
        end
    end

    // Result registers load on the final shift so they are valid with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else if (last_shift) begin
            bcd_q <= ovf_pending ? {DIGITS{4'h9}} : shift_reg_shifted[SR_W-1:BIN_WIDTH];
            ovf_q <= ovf_pending;
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks for bin2bcd_seq.
module tb_bin2bcd_seq;

    logic clk;
    logic reset;
    int   check_count;
    int   pass_count;
    int   last_cycles;
    int   last_busy;
    bit   last_stable;

    bin2bcd_seq_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

    bin2bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns past the next rising edge, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        assert (got === exp) pass_count++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Decimal reference model, independent of the shift-and-add method.
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called just after the accepting edge; returns at the done cycle or a bound.
    task automatic wait_done();
        logic [15:0] held;
        held        = bus.bcd;
        last_cycles = 1;
        last_busy   = 0;
        last_stable = 1'b1;
        while (bus.done !== 1'b1 && last_cycles < 40) begin
            if (bus.busy === 1'b1) last_busy++;
            if (bus.bcd !== held) last_stable = 1'b0;
            tick();
            last_cycles++;
        end
    endtask

    task automatic apply_stimulus(input logic [13:0] val);
        bus.bin   = val;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.bin   = ~val;
    endtask

    task automatic check_output(input string tag, input logic [13:0] val,
                                input logic [15:0] exp_bcd, input logic exp_ovf);
        apply_stimulus(val);
        wait_done();
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".cycles"}, 32'(last_cycles), 32'd15);
        check({tag, ".busycnt"}, 32'(last_busy), 32'd14);
        check({tag, ".stable"}, 32'(last_stable), 32'd1);
        check({tag, ".bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    endtask

    // Directed sequence followed by a random sweep.
    initial begin
        int dones;
        int busys;
        int v;
        check_count = 0;
        pass_count  = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.bin     = '0;
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.bcd", 32'(bus.bcd), 32'd0);
        check("rst.ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();

        $display("[TB] directed conversions");
        check_output("d1234", 14'd1234, 16'h1234, 1'b0);
        check_output("d0", 14'd0, 16'h0000, 1'b0);
        check_output("d9999", 14'd9999, 16'h9999, 1'b0);
        check_output("d10000", 14'd10000, 16'h9999, 1'b1);
        check_output("d16383", 14'd16383, 16'h9999, 1'b1);

        $display("[TB] start during conversion is ignored");
        apply_stimulus(14'd777);
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            bus.start = (c == 5);
            bus.bin   = (c == 5) ? 14'd42 : 14'd777;
            if (bus.done === 1'b1) dones++;
            tick();
        end
        bus.start = 1'b0;
        check("ign.early_done", 32'(dones), 32'd0);
        check("ign.done", 32'(bus.done), 32'd1);
        check("ign.bcd", 32'(bus.bcd), 32'h0777);
        check("ign.ovf", 32'(bus.ovf), 32'd0);
        tick();
        dones = 0;
        busys = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busys++;
            tick();
        end
        check("ign.extra_done", 32'(dones), 32'd0);
        check("ign.extra_busy", 32'(busys), 32'd0);

        $display("[TB] back-to-back with start held high");
        bus.bin   = 14'd8;
        bus.start = 1'b1;
        tick();
        bus.bin = 14'd9;
        wait_done();
        check("b2b.cycles0", 32'(last_cycles), 32'd15);
        check("b2b.bcd0", 32'(bus.bcd), 32'h0008);
        tick();
        bus.bin = 14'd10;
        check("b2b.restart0", 32'(bus.busy), 32'd1);
        wait_done();
        check("b2b.cycles1", 32'(last_cycles), 32'd15);
        check("b2b.bcd1", 32'(bus.bcd), 32'h0009);
        tick();
        bus.start = 1'b0;
        bus.bin   = 14'd99;
        wait_done();
        check("b2b.cycles2", 32'(last_cycles), 32'd15);
        check("b2b.bcd2", 32'(bus.bcd), 32'h0010);
        tick();
        check("b2b.idle", 32'(bus.busy), 32'd0);

        $display("[TB] asynchronous reset mid-conversion");
        check_output("pre_rst", 14'd16383, 16'h9999, 1'b1);
        apply_stimulus(14'd4321);
        for (int c = 1; c < 7; c++) tick();
        #2 reset = 1'b0;
        #1;
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.done", 32'(bus.done), 32'd0);
        check("arst.bcd", 32'(bus.bcd), 32'd0);
        check("arst.ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        dones = 0;
        busys = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busys++;
            tick();
        end
        check("arst.no_done", 32'(dones), 32'd0);
        check("arst.no_busy", 32'(busys), 32'd0);
        check_output("post_rst", 14'd4321, 16'h4321, 1'b0);

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 16383));
            apply_stimulus(14'(v));
            wait_done();
            check("rnd.cycles", 32'(last_cycles), 32'd15);
            check("rnd.stable", 32'(last_stable), 32'd1);
            check("rnd.bcd", 32'(bus.bcd), 32'(ref_bcd(v)));
            check("rnd.ovf", 32'(bus.ovf), 32'(v > 9999));
            tick();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock. It converts a 14-bit binary count into four packed BCD digits, which can drive the seven-segment controller's 16-bit data input. It is the inverse of the BCD-to-binary conversion on the LED path. Handshake is a start strobe followed by a one-cycle `done` pulse; the result is held until the next conversion completes.

## Interface
- `BIN_WIDTH`, default 14: width of binary input.
- `DIGITS`, default 4: number of BCD output digits.
- `clk`  input  1: system clock, rising edge.
- `reset`  input  1: asynchronous, active-low reset (0 = reset).
- `start`  input  1: request a conversion of `bin`; sampled only when not busy.
- `bin`  input  BIN_WIDTH: binary value, captured on the accepted `start` cycle only.
- `busy`  output  1: conversion in progress.
- `done`  output  1: one-cycle pulse; `bcd` and `ovf` are valid from this cycle on.
- `bcd`  output  4*DIGITS: packed digits, digit 0 in [3:0], most significant digit in the top nibble.
- `ovf`  output  1: the last converted value exceeded 10^DIGITS−1.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `start`=1 → capture `bin` into the low end of the shift register (width 4*DIGITS+BIN_WIDTH), clear the BCD field, set the bit counter to BIN_WIDTH, and go to SHIFT.
  - Compute `ovf_next` = (`bin` > 10^DIGITS−1) and hold it internally.
- **SHIFT, each cycle:**
  - Every BCD nibble ≥5 gets +3 (all nibbles adjusted in parallel, 4-bit add, no carry between nibbles).
  - Then the whole register shifts left by 1 and the counter decrements.
  - When the counter reaches 1 and that cycle's shift has been done, go to DONE.
- **DONE, one cycle:**
  - `done`=1.
  - `bcd` is loaded from the BCD field, or set to all nibbles 4'h9 when `ovf_next`=1.
  - `ovf` is loaded with `ovf_next`.
  - `start`=1 in this cycle is accepted exactly as in IDLE and goes to SHIFT. Otherwise go to IDLE.
- `start` during SHIFT is ignored. No queueing.
- `bin` changes outside the capture cycle have no effect.
- `bcd` and `ovf` change only in the DONE cycle. They are stable at all other times.
- **Saturation:** with the defaults, inputs 10000–16383 give `bcd`=16'h9999 and `ovf`=1.
- **Reset (asserted low, asynchronous):**
  - state = IDLE, `busy`=0, `done`=0, `bcd`=0, `ovf`=0, counter = 0.
  - Reset during SHIFT aborts the conversion. No `done` is produced.

## Timing
- Start accepted on edge T0 → `busy`=1 from T0+1 through T0+BIN_WIDTH (14 cycles).
- `done`=1 and new `bcd` appear at T0+BIN_WIDTH+1 (cycle 15 with defaults); `busy`=0 in that cycle.
- Minimum start-to-start spacing is BIN_WIDTH+1 cycles. Back-to-back operation is achieved by holding `start` high through DONE.
- `busy` and `done` are registered (state-decoded from a registered state). There are no combinational paths from inputs to outputs.
- The counter width is $clog2(BIN_WIDTH+1).

## Structure
- **Package `bin2bcd_pkg`:**
  - state enum `bcd_state_t` {IDLE, SHIFT, DONE};
  - function `bcd_max(DIGITS)` returning 10^DIGITS−1;
  - constant `NIBBLE_ADJ_THRESH` = 5.
- **Sub-module `bcd_digit_adj`:** combinational, 4-bit in/out, adds 3 if ≥5. It is instantiated DIGITS times with a generate loop.
- **Top level:** FSM, shift register, counter and output registers, all in `bin2bcd_seq`.

## Test plan
- After reset release: `bin`=1234, `start` pulsed 1 cycle → `busy` high for 14 cycles, `done` at cycle 15, `bcd`=16'h1234, `ovf`=0.
- Boundaries: `bin`=0 → 16'h0000; `bin`=9999 → 16'h9999 with `ovf`=0; `bin`=10000 and `bin`=16383 → 16'h9999 with `ovf`=1.
- `start` re-pulsed with `bin`=42 at cycle 5 of a conversion of 777 → ignored; `done` still at cycle 15 with 16'h0777, and only one `done` pulse.
- `start` held high continuously with `bin` stepping 8, 9, 10 at each acceptance → `done` every 15 cycles with 16'h0008, 16'h0009, 16'h0010.
- `reset` driven low at cycle 7 of a conversion → `busy`, `done`, `bcd` and `ovf` go to 0 immediately (asynchronously). After release there is no `done` until a new `start`.
- Random sweep of 1000 values against a reference model → `bcd` matches decimal digits and `ovf` is correct; `bcd` never changes outside a `done` cycle.
